// File: rtl/poker_bet_sequencer.sv
// rtl/poker_bet_sequencer.sv - betting-round controller: chip/pot ownership, round-robin bet grant, add-ten sequencing
module poker_bet_sequencer #(
  parameter int W          = 8,
  parameter int STEP       = 10,
  parameter int INIT_CHIPS = 100,
  parameter int ADD_LAT    = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init,
  input  logic [1:0]   bet_req,
  input  logic         award,
  input  logic         winner,
  input  logic [W-1:0] add_o,
  output logic [W-1:0] add_b,
  output logic         add_s,
  output logic [1:0]   bet_ack,
  output logic [1:0]   bet_nack,
  output logic [W-1:0] chips0,
  output logic [W-1:0] chips1,
  output logic [W-1:0] pot,
  output logic         busy
);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_COMMIT, S_REJ} state_e;

  localparam int            CW       = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam logic [W-1:0]  STEP_W   = W'(STEP);
  localparam logic [W-1:0]  INIT_W   = W'(INIT_CHIPS);
  localparam logic [W-1:0]  POT_MAX  = {W{1'b1}} - STEP_W;
  localparam logic [CW-1:0] LAT_LAST = CW'(ADD_LAT - 1);

  state_e        state_q, state_d;
  logic [W-1:0]  chips0_q, chips0_d, chips1_q, chips1_d, pot_q, pot_d;
  logic          rr_q, rr_d, gnt_q, gnt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          gnt_sel, grant_ok;
  logic [W:0]    win_sum;
  logic [W-1:0]  win_sat;

  // Both requesting: the round-robin pointer decides; otherwise the lone requester wins.
  assign gnt_sel  = (bet_req == 2'b11) ? rr_q : bet_req[1];
  assign grant_ok = ((gnt_sel ? chips1_q : chips0_q) >= STEP_W) && (pot_q <= POT_MAX);
  assign win_sum  = {1'b0, (winner ? chips1_q : chips0_q)} + {1'b0, pot_q};
  assign win_sat  = win_sum[W] ? {W{1'b1}} : win_sum[W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      chips0_q <= INIT_W;
      chips1_q <= INIT_W;
      pot_q    <= '0;
      rr_q     <= 1'b0;
      gnt_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      chips0_q <= chips0_d;
      chips1_q <= chips1_d;
      pot_q    <= pot_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    if (init) begin
      state_d = S_IDLE;
      rr_d    = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!award && (bet_req != 2'b00)) begin
            gnt_d   = gnt_sel;
            rr_d    = ~gnt_sel;
            cnt_d   = '0;
            state_d = grant_ok ? S_ADD : S_REJ;
          end
        end
        S_ADD: begin
          if (cnt_q == LAT_LAST) state_d = S_COMMIT;
          else                   cnt_d   = cnt_q + 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    chips0_d = chips0_q;
    chips1_d = chips1_q;
    pot_d    = pot_q;
    if (init) begin
      chips0_d = INIT_W;
      chips1_d = INIT_W;
      pot_d    = '0;
    end else if (state_q == S_IDLE && award) begin
      pot_d = '0;
      if (winner) chips1_d = win_sat;
      else        chips0_d = win_sat;
    end else if (state_q == S_COMMIT) begin
      pot_d = add_o;
      if (gnt_q) chips1_d = chips1_q - STEP_W;
      else       chips0_d = chips0_q - STEP_W;
    end
  end

  // init in the COMMIT/REJ cycle aborts the op, so the handshake pulse is suppressed too.
  always_comb begin
    add_s    = (state_q == S_ADD);
    add_b    = pot_q;
    bet_ack  = 2'b00;
    bet_nack = 2'b00;
    if (state_q == S_COMMIT && !init) bet_ack  = gnt_q ? 2'b10 : 2'b01;
    if (state_q == S_REJ && !init)    bet_nack = gnt_q ? 2'b10 : 2'b01;
    chips0   = chips0_q;
    chips1   = chips1_q;
    pot      = pot_q;
    busy     = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_poker_bet_sequencer.sv
// tb/tb_poker_bet_sequencer.sv - directed self-checking bench for poker_bet_sequencer
module tb_poker_bet_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init = 1'b0, award = 1'b0, winner = 1'b0;
  logic [1:0] bet_req = 2'b00, b_bet_req = 2'b00;

  logic [7:0] add_o, add_b, chips0, chips1, pot;
  logic       add_s, busy;
  logic [1:0] bet_ack, bet_nack;

  logic [7:0] b_add_o, b_add_b, b_chips0, b_chips1, b_pot;
  logic       b_add_s, b_busy;
  logic [1:0] b_bet_ack, b_bet_nack;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Ideal add-ten units
  assign add_o   = add_b + 8'd10;
  assign b_add_o = b_add_b + 8'd10;

  poker_bet_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .init(init), .bet_req(bet_req), .award(award),
    .winner(winner), .add_o(add_o), .add_b(add_b), .add_s(add_s),
    .bet_ack(bet_ack), .bet_nack(bet_nack), .chips0(chips0), .chips1(chips1),
    .pot(pot), .busy(busy)
  );

  // Larger bankroll so the pot can reach the overflow guard; two-cycle adder.
  poker_bet_sequencer #(.W(8), .STEP(10), .INIT_CHIPS(200), .ADD_LAT(2)) u_big (
    .clk(clk), .rst_n(rst_n), .init(init), .bet_req(b_bet_req), .award(award),
    .winner(winner), .add_o(b_add_o), .add_b(b_add_b), .add_s(b_add_s),
    .bet_ack(b_bet_ack), .bet_nack(b_bet_nack), .chips0(b_chips0), .chips1(b_chips1),
    .pot(b_pot), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_init();
    init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  task automatic bet_main(input logic [1:0] r);
    bit done;
    done = 1'b0;
    bet_req = r;
    tick();
    bet_req = 2'b00;
    for (int i = 0; i < 10 && !done; i++) begin
      if ((bet_ack | bet_nack) != 2'b00) done = 1'b1;
      else tick();
    end
    chk("bet_main_done", done, 1);
    tick();
  endtask

  initial begin
    int         n;
    logic [1:0] ord [3];

    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    chk("rst_chips0", chips0, 100);
    chk("rst_chips1", chips1, 100);
    chk("rst_pot", pot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_add_s", add_s, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_big_chips0", b_chips0, 200);

    // Big instance: alternate bets up to pot 250, then overflow-guard reject.
    b_bet_req = 2'b11;
    n = 0;
    for (int c = 0; c < 300 && n < 25; c++) begin
      tick();
      if (b_bet_ack != 2'b00) begin
        n++;
        if (n == 25) b_bet_req = 2'b00;
      end
    end
    chk("big_ack_count", n, 25);
    tick();
    chk("big_pot_250", b_pot, 250);
    chk("big_chips0", b_chips0, 70);
    chk("big_chips1", b_chips1, 80);
    b_bet_req = 2'b01;
    tick();
    chk("big_nack_pot_full", b_bet_nack, 2'b01);
    chk("big_no_ack", b_bet_ack, 2'b00);
    b_bet_req = 2'b00;
    tick();
    chk("big_pot_kept", b_pot, 250);
    chk("big_chips0_kept", b_chips0, 70);
    winner = 1'b0;
    award = 1'b1;
    tick();
    award = 1'b0;
    chk("big_award_sat", b_chips0, 255);
    chk("big_award_pot0", b_pot, 0);
    chk("main_award_empty_pot", chips0, 100);

    // Single bet with latency check
    bet_req = 2'b01;
    tick();
    chk("t2_add_s", add_s, 1);
    chk("t2_busy", busy, 1);
    chk("t2_add_b", add_b, 0);
    chk("t2_no_early_ack", bet_ack, 0);
    bet_req = 2'b00;
    tick();
    chk("t2_ack", bet_ack, 2'b01);
    chk("t2_add_s_low", add_s, 0);
    tick();
    chk("t2_pot", pot, 10);
    chk("t2_chips0", chips0, 90);
    chk("t2_chips1", chips1, 100);
    chk("t2_ack_gone", bet_ack, 0);

    // Both requesting: round-robin from player 0 after init
    pulse_init();
    chk("t3_init_pot", pot, 0);
    chk("t3_init_chips0", chips0, 100);
    bet_req = 2'b11;
    n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      tick();
      if (bet_ack != 2'b00) begin
        ord[n] = bet_ack;
        n++;
        if (n == 3) bet_req = 2'b00;
      end
    end
    chk("t3_ack_count", n, 3);
    chk("t3_order0", ord[0], 2'b01);
    chk("t3_order1", ord[1], 2'b10);
    chk("t3_order2", ord[2], 2'b01);
    tick();
    chk("t3_pot", pot, 30);
    chk("t3_chips0", chips0, 80);
    chk("t3_chips1", chips1, 90);

    // Drain player 1 then bet with insufficient chips
    for (int i = 0; i < 9; i++) bet_main(2'b10);
    chk("t4_chips1_empty", chips1, 0);
    chk("t4_pot", pot, 120);
    bet_req = 2'b10;
    tick();
    chk("t4_nack", bet_nack, 2'b10);
    chk("t4_no_ack", bet_ack, 0);
    bet_req = 2'b00;
    tick();
    chk("t4_pot_kept", pot, 120);
    chk("t4_chips1_kept", chips1, 0);
    chk("t4_chips0_kept", chips0, 80);

    // Award to player 1
    pulse_init();
    for (int i = 0; i < 4; i++) bet_main(2'b10);
    chk("t5_pot40", pot, 40);
    chk("t5_chips1_60", chips1, 60);
    winner = 1'b1;
    award = 1'b1;
    tick();
    award = 1'b0;
    chk("t5_award_chips1", chips1, 100);
    chk("t5_award_pot", pot, 0);
    chk("t5_award_chips0", chips0, 100);

    // Award while busy is ignored
    bet_req = 2'b01;
    tick();
    bet_req = 2'b00;
    winner = 1'b0;
    award = 1'b1;
    tick();
    award = 1'b0;
    chk("t5_busy_ack", bet_ack, 2'b01);
    tick();
    chk("t5_busy_pot", pot, 10);
    chk("t5_busy_chips0", chips0, 90);

    // init during ADD aborts without ack
    bet_req = 2'b10;
    tick();
    bet_req = 2'b00;
    chk("t6_in_add", add_s, 1);
    init = 1'b1;
    tick();
    init = 1'b0;
    chk("t6_abort_ack", bet_ack, 0);
    chk("t6_abort_busy", busy, 0);
    chk("t6_abort_pot", pot, 0);
    chk("t6_abort_chips0", chips0, 100);
    chk("t6_abort_chips1", chips1, 100);
    tick();
    chk("t6_abort_ack_late", bet_ack, 0);

    // Asynchronous reset in the middle of COMMIT
    bet_req = 2'b01;
    tick();
    bet_req = 2'b00;
    tick();
    chk("t6_commit_ack", bet_ack, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_ack", bet_ack, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_pot", pot, 0);
    chk("t6_rst_chips0", chips0, 100);
    chk("t6_rst_add_s", add_s, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
